// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared helpers for the pipelined adder/subtractor:
//   ceil_div  - pipeline depth from word width and slice width
//   slice_lo  - lowest bit index of slice k
//   slice_hi  - highest bit index of slice k (last slice may be narrower)
//   full_add  - one full-adder cell, returns {carry_out, sum}
// The per-stage record depends on the top's WIDTH parameter, so its typedef
// lives inside pipe_adder where that width is known.
// ----------------------------------------------------------------------------
package adder_pkg;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned chunk);
        return k * chunk;
    endfunction

    function automatic int unsigned slice_hi(input int unsigned k, input int unsigned chunk,
                                             input int unsigned width);
        int unsigned top;
        top = (k + 1) * chunk;
        if (top > width) begin
            top = width;
        end
        return top - 1;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// ----------------------------------------------------------------------------
// adder_chunk
// Combinational W-bit ripple-carry slice built from full-adder cells.
// Ports:
//   a, b   [W-1:0] in   slice operands
//   ci             in   carry into bit 0
//   sum    [W-1:0] out  slice sum
//   co             out  carry out of the top bit
//   c_top          out  carry into the top bit (for overflow detection)
// ----------------------------------------------------------------------------
module adder_chunk
    import adder_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_top
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
        end
    end

    assign co    = c[W];
    assign c_top = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// ----------------------------------------------------------------------------
// pipe_adder
// Pipelined WIDTH-bit adder/subtractor. One CHUNK-bit slice of the carry
// chain resolves per stage; stages form an elastic pipeline with valid/ready
// handshakes on both ends, and empty stages are filled even while the output
// is stalled, so a bubble never costs throughput.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    input handshake
//   a, b     [WIDTH-1:0]  operands
//   ci                    carry-in (ignored when sub=1)
//   sub                   1: a - b
//   out_valid, out_ready  output handshake
//   sum      [WIDTH-1:0]  result modulo 2^WIDTH
//   co                    carry out of MSB (for sub: 1 = no borrow)
//   ov                    two's-complement overflow
// ----------------------------------------------------------------------------
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov
);

    localparam int unsigned STAGES = ceil_div(WIDTH, CHUNK);

    // psum bits above the slices resolved so far are always zero.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] psum;
        logic             carry;
    } stage_t;

    stage_t            st_q [STAGES];
    logic              ov_q;
    logic [STAGES:0]   adv;

    // adv[k]: stage k may load this cycle. A stage that is empty can always
    // load, which is what squeezes bubbles out of a stalled pipe.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~st_q[k].valid | adv[k+1];
        end
    end

    // Nothing is accepted while reset is being sampled.
    assign in_ready = adv[0] & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned Lo = slice_lo(k, CHUNK);
        localparam int unsigned Hi = slice_hi(k, CHUNK, WIDTH);
        localparam int unsigned W  = Hi - Lo + 1;

        stage_t           src;
        logic [W-1:0]     slice_sum;
        logic             slice_co;
        logic             slice_c_top;
        logic [WIDTH-1:0] psum_d;

        if (k == 0) begin : g_src_in
            // Subtraction is a + ~b + 1.
            assign src = '{
                valid: in_valid,
                a:     a,
                b:     b ^ {WIDTH{sub}},
                psum:  '0,
                carry: sub ? 1'b1 : ci
            };
        end else begin : g_src_prev
            assign src = st_q[k-1];
        end

        adder_chunk #(
            .W (W)
        ) u_chunk (
            .a     (src.a[Hi:Lo]),
            .b     (src.b[Hi:Lo]),
            .ci    (src.carry),
            .sum   (slice_sum),
            .co    (slice_co),
            .c_top (slice_c_top)
        );

        always_comb begin
            psum_d        = src.psum;
            psum_d[Hi:Lo] = slice_sum;
        end

        // Payload only moves with a valid transaction so held results and
        // idle registers stay put.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q[k] <= '0;
            end else if (adv[k]) begin
                st_q[k].valid <= src.valid;
                if (src.valid) begin
                    st_q[k].a     <= src.a;
                    st_q[k].b     <= src.b;
                    st_q[k].psum  <= psum_d;
                    st_q[k].carry <= slice_co;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_q <= 1'b0;
                end else if (adv[k] && src.valid) begin
                    ov_q <= slice_co ^ slice_c_top;
                end
            end

            // Operands are not needed once the final slice is resolved.
            logic unused_operands;
            assign unused_operands = ^{st_q[k].a, st_q[k].b};
        end else begin : g_mid
            logic unused_c_top;
            assign unused_c_top = slice_c_top;
        end
    end

    assign out_valid = st_q[STAGES-1].valid;
    assign sum       = st_q[STAGES-1].psum;
    assign co        = st_q[STAGES-1].carry;
    assign ov        = ov_q;

endmodule

// File: tb/tb_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_pipe_adder
// Bench for pipe_adder: a 16/4 instance driven from a vector table, streaming
// sequences (stall, bubbles, reset) and a 10/4 instance for the narrow last
// slice.
// ----------------------------------------------------------------------------
module tb_pipe_adder;

    localparam int unsigned STAGES   = 4;
    localparam int unsigned STAGES10 = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        ci, sub, co, ov;

    logic        in_valid10, in_ready10, out_valid10, out_ready10;
    logic [9:0]  a10, b10, sum10;
    logic        ci10, sub10, co10, ov10;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    pipe_adder #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ov        (ov)
    );

    pipe_adder #(
        .WIDTH (10),
        .CHUNK (4)
    ) dut10 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid10),
        .in_ready  (in_ready10),
        .a         (a10),
        .b         (b10),
        .ci        (ci10),
        .sub       (sub10),
        .out_valid (out_valid10),
        .out_ready (out_ready10),
        .sum       (sum10),
        .co        (co10),
        .ov        (ov10)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {co, ov, sum} from plain integer arithmetic.
    function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [15:0] yy;
        logic        cin;
        logic [16:0] full;
        logic [15:0] low;
        yy   = s ? ~y : y;
        cin  = s ? 1'b1 : c;
        full = {1'b0, x} + {1'b0, yy} + {16'b0, cin};
        low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'b0, cin};
        return {full[16], low[15] ^ full[16], full[15:0]};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int acc;
        bit got;
        got      = 1'b0;
        a        = v.a;
        b        = v.b;
        ci       = v.ci;
        sub      = v.sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        acc = cyc;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else step();
        end
        check({tag, "_latency"}, got ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'(STAGES));
        check({tag, "_sum"}, 32'(sum), 32'(v.sum));
        check({tag, "_co"}, 32'(co), 32'(v.co));
        check({tag, "_ov"}, 32'(ov), 32'(v.ov));
        step();
        check({tag, "_single"}, 32'(out_valid), 32'd0);
    endtask

    // Streams ntx random transactions; in_valid per cycle follows ivpat,
    // out_ready follows orpat. Logs in_ready and out_valid per cycle.
    task automatic stream(input logic [31:0] ivpat, input logic [31:0] orpat, input int ntx,
                          output logic [31:0] ir_log, output logic [31:0] ov_log);
        logic [15:0] ta [8];
        logic [15:0] tb [8];
        logic        tc [8];
        logic        ts [8];
        logic [17:0] q [$];
        logic [17:0] held_val;
        logic [17:0] exp;
        int          sent, recv, extra;
        bit          held;
        sent  = 0;
        recv  = 0;
        extra = 0;
        held  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ta[i] = 16'($urandom);
            tb[i] = 16'($urandom);
            tc[i] = 1'($urandom);
            ts[i] = 1'($urandom);
        end
        ir_log = '0;
        ov_log = '0;
        for (int c = 0; c < 24; c++) begin
            in_valid = ivpat[c] && (sent < ntx);
            if (sent < ntx) begin
                a   = ta[sent];
                b   = tb[sent];
                ci  = tc[sent];
                sub = ts[sent];
            end
            out_ready = orpat[c];
            #1;
            ir_log[c] = in_ready;
            ov_log[c] = out_valid;
            if (held) begin
                check("stall_hold_value", 32'({co, ov, sum}), 32'(held_val));
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                held = 1'b0;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref16(a, b, ci, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    extra++;
                end else begin
                    exp = q.pop_front();
                    check("stream_result", 32'({co, ov, sum}), 32'(exp));
                    recv++;
                end
            end else if (out_valid) begin
                held     = 1'b1;
                held_val = {co, ov, sum};
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(recv), 32'(ntx));
        check("stream_no_extra", 32'(extra), 32'd0);
    endtask

    task automatic run10(input logic [9:0] x, input logic [9:0] y, input logic s,
                         input logic [9:0] es, input logic eco, input logic eov);
        int acc;
        bit got;
        got        = 1'b0;
        a10        = x;
        b10        = y;
        sub10      = s;
        in_valid10 = 1'b1;
        #1;
        check("w10_in_ready", 32'(in_ready10), 32'd1);
        acc = cyc;
        step();
        in_valid10 = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (out_valid10) got = 1'b1;
            else step();
        end
        check("w10_latency", got ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'(STAGES10));
        check("w10_sum", 32'(sum10), 32'(es));
        check("w10_co", 32'(co10), 32'(eco));
        check("w10_ov", 32'(ov10), 32'(eov));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ir_log, ov_log;
        bit          saw;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        ci          = 1'b0;
        sub         = 1'b0;
        in_valid10  = 1'b0;
        out_ready10 = 1'b1;
        a10         = '0;
        b10         = '0;
        ci10        = 1'b0;
        sub10       = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_ov", 32'(ov), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_w10_out_valid", 32'(out_valid10), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset with three transactions in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a        = 16'h1111 * 16'(i + 1);
            b        = 16'h0101;
            ci       = 1'b0;
            sub      = 1'b0;
            in_valid = 1'b1;
            step();
        end
        rst      = 1'b1;
        a        = 16'hAAAA;
        in_valid = 1'b1;
        #1;
        check("in_ready_during_rst", 32'(in_ready), 32'd0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_sum", 32'(sum), 32'd0);
        check("post_rst_co", 32'(co), 32'd0);
        check("post_rst_ov", 32'(ov), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        check("post_rst_no_stale", 32'(saw), 32'd0);
        run_vec(vecs[3], "post_rst");

        // Back-to-back with a 3-cycle output stall after the 2nd result.
        stream(32'hFFFF_FFFF, 32'hFFFF_FE3F, 8, ir_log, ov_log);
        check("stall_in_ready", 32'(ir_log[9:5]), 32'b10001);
        check("stall_out_valid", 32'(ov_log[15:0]), 32'h7FF0);

        // Input pattern 1,0,1,0 reappears at the output 4 cycles later.
        stream(32'h0000_0005, 32'hFFFF_FFFF, 2, ir_log, ov_log);
        check("bubble_out_valid", 32'(ov_log[9:0]), 32'h050);
        check("bubble_in_ready", 32'(ir_log[7:0]), 32'hFF);

        // Output stalled with a bubble in flight: input side keeps flowing.
        stream(32'h0000_001D, 32'hFFFF_FFEF, 4, ir_log, ov_log);
        check("collapse_in_ready", 32'(ir_log[4]), 32'd1);
        check("collapse_out_valid", 32'(ov_log[9:4]), 32'h1F);

        // Narrow last slice.
        run10(10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0);
        run10(10'h1FF, 10'h001, 1'b0, 10'h200, 1'b0, 1'b1);
        run10(10'h000, 10'h001, 1'b1, 10'h3FF, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
